// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit path: controller state encoding
// and the default frame parameters used by the controller and its top level.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;

endpackage

// File: rtl/rs232_tx_ctrl.sv
// RS232 transmit controller: frames a latched word as start, LSB-first data,
// optional parity and stop bits, paced by the rs232_clk_gen bit strobe.
module rs232_tx_ctrl
  import rs232_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  clk_rs232_en,
  output logic                  gen_clr,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int              CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic            STOP_LAST = (STOP_BITS > 1);

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  parity_bit;
  logic                  bit_end;

  // The strobe landing on the generator-restart cycle belongs to the old
  // period, so it must not end the freshly started start bit.
  assign bit_end = clk_rs232_en & ~gen_clr;
  assign tx_busy = ~tx_ready;

  // NOTE: every register here uses <= so all next-state terms read the values
  // from before the edge; a blocking = would let later lines see updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shift register is plain flops, not a memory, so it is cleared
      // with the rest of the datapath and never carries stale data out of reset.
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      gen_clr    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      gen_clr <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            shreg      <= tx_data;
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b0;
            gen_clr    <= 1'b1;
            tx_ready   <= 1'b0;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_ctrl.sv
// Bench for rs232_tx_ctrl: three configurations (8N1, 8E1, 8O2) share stimulus;
// a frame-level model predicts every output each cycle, plus literal waveform checks.
module tb_rs232_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       force_en = 1'b0;
  logic       cmp_en = 1'b0;

  logic [2:0] tx_ready_v, gen_clr_v, tx_v, tx_busy_v, tx_done_v, en_v;
  logic [1:0] cnt [3] = '{default: 2'd0};

  // Per-instance configuration: parity enable, odd parity, two stop bits.
  localparam logic [2:0] PE_MASK  = 3'b110;
  localparam logic [2:0] PO_MASK  = 3'b100;
  localparam logic [2:0] SB2_MASK = 3'b100;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rs232_tx_ctrl #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_v[0]),
    .clk_rs232_en(en_v[0]), .gen_clr(gen_clr_v[0]), .tx(tx_v[0]), .tx_busy(tx_busy_v[0]),
    .tx_done(tx_done_v[0]));

  rs232_tx_ctrl #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_v[1]),
    .clk_rs232_en(en_v[1]), .gen_clr(gen_clr_v[1]), .tx(tx_v[1]), .tx_busy(tx_busy_v[1]),
    .tx_done(tx_done_v[1]));

  rs232_tx_ctrl #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_v[2]),
    .clk_rs232_en(en_v[2]), .gen_clr(gen_clr_v[2]), .tx(tx_v[2]), .tx_busy(tx_busy_v[2]),
    .tx_done(tx_done_v[2]));

  // Bit-period generator, ratio 4: the restart cycle counts as the first cycle.
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      cnt[i] <= (gen_clr_v[i] === 1'b1) ? 2'd1 : cnt[i] + 2'd1;

  assign en_v[0] = force_en | (cnt[0] == 2'd3);
  assign en_v[1] = force_en | (cnt[1] == 2'd3);
  assign en_v[2] = force_en | (cnt[2] == 2'd3);

  function automatic logic [15:0] frame_of(int i, logic [7:0] d);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    if (PE_MASK[i]) f[9] = (^d) ^ PO_MASK[i];
    return f;
  endfunction

  function automatic int len_of(int i);
    return 10 + int'(PE_MASK[i]) + int'(SB2_MASK[i]);
  endfunction

  // Model: a frame is a list of bits; each counted strobe moves to the next bit.
  logic        m_busy  [3] = '{default: 1'b0};
  logic        m_first [3] = '{default: 1'b0};
  logic        m_done  [3] = '{default: 1'b0};
  int          m_idx   [3] = '{default: 0};
  int          m_len   [3] = '{default: 10};
  logic [15:0] m_bits  [3] = '{default: 16'hFFFF};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i]  <= 1'b0;
        m_first[i] <= 1'b0;
        m_done[i]  <= 1'b0;
        m_idx[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy[i]) begin
          m_done[i] <= 1'b0;
          if (tx_valid) begin
            m_bits[i]  <= frame_of(i, tx_data);
            m_len[i]   <= len_of(i);
            m_busy[i]  <= 1'b1;
            m_idx[i]   <= 0;
            m_first[i] <= 1'b1;
          end
        end else begin
          m_first[i] <= 1'b0;
          if (en_v[i] && !m_first[i]) begin
            if (m_idx[i] + 1 == m_len[i]) begin
              m_busy[i] <= 1'b0;
              m_done[i] <= 1'b1;
            end else begin
              m_idx[i] <= m_idx[i] + 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("inst%0d_tx", i), 32'(tx_v[i]),
              32'(m_busy[i] ? m_bits[i][m_idx[i]] : 1'b1));
        check($sformatf("inst%0d_tx_ready", i), 32'(tx_ready_v[i]), 32'(!m_busy[i]));
        check($sformatf("inst%0d_tx_busy", i), 32'(tx_busy_v[i]), 32'(m_busy[i]));
        check($sformatf("inst%0d_tx_done", i), 32'(tx_done_v[i]), 32'(m_done[i]));
        check($sformatf("inst%0d_gen_clr", i), 32'(gen_clr_v[i]), 32'(m_busy[i] && m_first[i]));
      end
    end
  end

  logic cap [3][64];
  int   done_at  [3];
  int   done_cnt [3];
  logic cap_clr0;

  task automatic send(input logic [7:0] d, input logic frc);
    @(posedge clk); #2;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    force_en = frc;
  endtask

  // Sample index 0 is the cycle right after acceptance (the generator restart cycle).
  task automatic capture(input int n, input logic toggle, input logic drop_valid);
    cap_clr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_at[i]  = -1;
      done_cnt[i] = 0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) cap_clr0 = gen_clr_v[0];
      for (int i = 0; i < 3; i++) begin
        cap[i][c] = tx_v[i];
        if (tx_done_v[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = c;
        end
      end
      if (toggle) tx_data = ~tx_data;
      if (drop_valid && c == 0) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(&tx_ready_v) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", 32'(&tx_ready_v), 32'd1);
  endtask

  function automatic logic [9:0] bits10();
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = cap[0][4*k+1];
    return v;
  endfunction

  function automatic int hold_errs();
    int bad = 0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        if (cap[0][4*k+j] !== cap[0][4*k+1]) bad++;
    return bad;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int pre_done;
    int k;
    logic [10:0] v11;

    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx", 32'(tx_v), 32'h7);
    check("reset_ready", 32'(tx_ready_v), 32'h7);
    check("reset_busy", 32'(tx_busy_v), 32'h0);
    check("reset_done", 32'(tx_done_v), 32'h0);
    check("reset_gen_clr", 32'(gen_clr_v), 32'h0);
    rst = 1'b1;

    // Idle with the generator running: no activity at all.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_v !== 3'b111 || tx_ready_v !== 3'b111 || gen_clr_v !== 3'b000) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);

    // 0xA5, 8N1.
    wait_idle();
    send(8'hA5, 1'b0);
    capture(52, 1'b0, 1'b0);
    check("a5_gen_clr_first", 32'(cap_clr0), 32'd1);
    check("a5_bits", 32'(bits10()), 32'h34A);
    check("a5_bit_hold", 32'(hold_errs()), 32'd0);
    check("a5_done_at", 32'(done_at[0]), 32'd40);
    check("a5_done_once", 32'(done_cnt[0]), 32'd1);

    // 0x07 with even parity (inst1) and odd parity, two stops (inst2).
    wait_idle();
    send(8'h07, 1'b0);
    capture(56, 1'b0, 1'b0);
    check("p07_even_parity", 32'(cap[1][37]), 32'd1);
    check("p07_odd_parity", 32'(cap[2][37]), 32'd0);
    check("p07_even_done_at", 32'(done_at[1]), 32'd44);
    check("p07_odd2_done_at", 32'(done_at[2]), 32'd48);

    // Back-to-back: tx_valid held, data swapped after the first acceptance.
    wait_idle();
    @(posedge clk); #2;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gen_clr_v[0] !== 1'b1 && k < 10);
    check("b2b_first_accept", 32'(gen_clr_v[0]), 32'd1);
    tx_data  = 8'hAA;
    pre_done = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_done_v[0] !== 1'b1 && k < 60);
    if (tx_done_v[0] === 1'b1) pre_done = 1;
    check("b2b_first_done_at", 32'(k), 32'd40);
    capture(46, 1'b0, 1'b1);
    check("b2b_second_gen_clr", 32'(cap_clr0), 32'd1);
    check("b2b_second_start", 32'(cap[0][0]), 32'd0);
    check("b2b_second_bits", 32'(bits10()), 32'h354);
    check("b2b_done_pulses", 32'(pre_done + done_cnt[0]), 32'd2);

    // Reset during data bit 3, then a clean frame.
    wait_idle();
    send(8'h3C, 1'b0);
    repeat (18) @(negedge clk);
    check("rst_mid_busy_before", 32'(tx_busy_v[0]), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx_v), 32'h7);
    check("rst_mid_ready", 32'(tx_ready_v), 32'h7);
    check("rst_mid_done", 32'(tx_done_v), 32'h0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_done_v !== 3'b000) bad++;
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_done_v !== 3'b000) bad++;
    end
    check("rst_no_done", 32'(bad), 32'd0);
    send(8'h3C, 1'b0);
    capture(52, 1'b0, 1'b0);
    check("post_rst_bits", 32'(bits10()), 32'h278);
    check("post_rst_done_at", 32'(done_at[0]), 32'd40);

    // Strobe forced high and tx_data toggling during the frame.
    wait_idle();
    send(8'h96, 1'b1);
    capture(20, 1'b1, 1'b0);
    force_en = 1'b0;
    for (int j = 0; j < 11; j++) v11[j] = cap[0][j];
    check("forced_bits", 32'(v11), 32'h658);
    check("forced_done_at", 32'(done_at[0]), 32'd11);
    wait_idle();

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rs232_tx_ctrl.md
RS232_TX_CTRL -- requirements
Module: rs232_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = insert parity bit after data.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bit count (1 or 2).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tx_data  input  DATA_WIDTH  byte to send.
REQ-008 SHALL have port tx_valid  input  1  tx_data valid request.
REQ-009 SHALL have port tx_ready  output  1  controller idle, able to accept.
REQ-010 SHALL have port clk_rs232_en  input  1  one-cycle bit-period strobe from rs232_clk_gen.
REQ-011 SHALL have port gen_clr  output  1  one-cycle synchronous restart of rs232_clk_gen divider.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  frame in progress.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal not tx_ready.
REQ-017 In IDLE, tx_valid=1 at an edge SHALL latch tx_data into a shift register and move to START; tx_data changes afterwards SHALL be ignored until the next acceptance.
REQ-018 In the cycle after acceptance, gen_clr SHALL be 1 for exactly one cycle and tx SHALL be 0, so that the start bit is aligned to a fresh bit period.
REQ-019 A clk_rs232_en strobe coincident with gen_clr SHALL be ignored.
REQ-020 Each later clk_rs232_en strobe SHALL end the current bit: START->DATA; DATA advances bit counter, ->PARITY (PARITY_EN=1) or ->STOP after bit DATA_WIDTH-1; PARITY->STOP; STOP->IDLE after STOP_BITS strobes.
REQ-021 DATA SHALL send LSB first; tx SHALL be registered with no glitches between bits.
REQ-022 Parity bit SHALL be XOR of the latched data, inverted when PARITY_ODD=1.
REQ-023 tx SHALL be 1 in STOP and IDLE.
REQ-024 Frame length SHALL be exactly 1+DATA_WIDTH+PARITY_EN+STOP_BITS bit periods.
REQ-025 tx_done SHALL pulse 1 cycle on the edge leaving STOP; tx_ready SHALL be 1 on that same cycle.
REQ-026 Back-to-back: tx_valid held high SHALL be accepted on the first IDLE cycle, with no extra idle bit period.
REQ-027 clk_rs232_en in IDLE SHALL be ignored; tx_valid outside IDLE SHALL be ignored (no queueing).
REQ-028 Bit counter SHALL be width clog2(DATA_WIDTH), with no wrap beyond DATA_WIDTH-1.

Reset
REQ-029 rst=0 SHALL force, asynchronously: state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, gen_clr=0, counters and shift register 0.
REQ-030 Reset mid-frame SHALL abort the frame with no tx_done pulse; the first acceptance after release SHALL follow REQ-017/018.

Structure
REQ-031 State encoding and default parameter values SHALL live in shared package rs232_pkg.
REQ-032 No sub-module SHALL be instantiated; rs232_tx_ctrl and rs232_clk_gen SHALL be instantiated side-by-side in the RS232 top, with gen_clr driving the generator restart.

Verification (rs232_clk_gen RS232_RATIO=4, 10 ns clock)
REQ-033 Reset held then released, no request -> tx=1, tx_ready=1, no gen_clr, for 1000 cycles.
REQ-034 Send 0xA5, 8N1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done once after 40 cycles.
REQ-035 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 11 bits.
REQ-036 tx_valid held high with 0x55 then 0xAA -> two frames, second start bit begins the cycle after tx_done + 1; exactly 2 tx_done pulses.
REQ-037 rst low during DATA bit 3 -> tx=1 immediately, tx_ready=1, no tx_done; next send 0x3C completes correctly.
REQ-038 tx_data toggled and clk_rs232_en forced high during a frame -> transmitted bits match the latched value; a strobe on the gen_clr cycle is not counted.
